video_chunk_request_scheduler: RTL

Sequences chunk requests for one video frame into the request FIFO that feeds the video generator source. On a frame-start pulse it walks every line and chunk of the active area and writes {vPos, chunkNum} words. It paces issue with credits, so no more than MAX_OUTSTANDING chunks are in flight between request issue and response consumption. It sits between the frame timing logic and the request FIFO, all in the scaler clock domain.

---
 rtl/video_pipeline_pkg.sv | 12 +
 rtl/video_credit_counter.sv | 33 +++
 rtl/video_chunk_request_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/video_pipeline_pkg.sv
// Shared sizes, request-word width helper and scheduler state type for the video pipeline.
package video_pipeline_pkg;
    localparam int HACTIVE_BITS   = 11;
    localparam int VACTIVE_BITS   = 11;
    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

    function automatic int req_width(input int v_bits, input int h_bits, input int chunk_bits);
        return v_bits + h_bits - chunk_bits;
    endfunction
endpackage

// File: rtl/video_credit_counter.sv
// Outstanding-chunk credit counter: up on issue, down on consume, sticky underflow flag.
module video_credit_counter #(
    parameter  int MAX = 4,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    output logic available,
    output logic zero,
    output logic underflow
);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] count;

    // inc is only ever asserted while available, so the count cannot pass MAX
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (inc && !dec) begin
            count <= count + ONE;
        end else if (dec && !inc) begin
            if (count == '0) underflow <= 1'b1;
            else             count     <= count - ONE;
        end
    end

    assign available = count < CW'(MAX);
    assign zero      = count == '0;
endmodule

// File: rtl/video_chunk_request_scheduler.sv
// Walks every {line, chunk} of a frame into the request FIFO, paced by chunk credits.
// Optional interlaced field order when VIDEO_SCHED_INTERLACE_EN is defined (adds fieldOdd).
module video_chunk_request_scheduler #(
    parameter  int CHUNK_BITS      = 5,
    parameter  int HACTIVE_BITS    = video_pipeline_pkg::HACTIVE_BITS,
    parameter  int VACTIVE_BITS    = video_pipeline_pkg::VACTIVE_BITS,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int REQ_W = video_pipeline_pkg::req_width(VACTIVE_BITS, HACTIVE_BITS, CHUNK_BITS)
) (
    input  logic                    scalerClock,
    input  logic                    resetN,
    input  logic                    frameStart,
    input  logic [HACTIVE_BITS-1:0] hActive,
    input  logic [VACTIVE_BITS-1:0] vActive,
`ifdef VIDEO_SCHED_INTERLACE_EN
    input  logic                    fieldOdd,
`endif
    output logic                    requestFifoWriteEnable,
    input  logic                    requestFifoFull,
    output logic [REQ_W-1:0]        requestFifoWriteData,
    input  logic                    chunkConsumed,
    output logic                    busy,
    output logic                    frameDone,
    output logic                    creditUnderflow
);
    import video_pipeline_pkg::*;

    localparam int CW = HACTIVE_BITS - CHUNK_BITS;
    localparam logic [HACTIVE_BITS:0] CHUNK_ROUND = (HACTIVE_BITS+1)'((1 << CHUNK_BITS) - 1);
    localparam logic [HACTIVE_BITS:0] CHUNK_ONE   = (HACTIVE_BITS+1)'(1);
`ifdef VIDEO_SCHED_INTERLACE_EN
    localparam logic [VACTIVE_BITS:0] LINE_STEP   = (VACTIVE_BITS+1)'(2);
`else
    localparam logic [VACTIVE_BITS:0] LINE_STEP   = (VACTIVE_BITS+1)'(1);
`endif

    sched_state_t            state, state_n;
    logic [HACTIVE_BITS:0]   chunks_per_line, cpl_in, chunk_nxt;
    logic [VACTIVE_BITS-1:0] v_lim, line_count, start_line;
    logic [VACTIVE_BITS:0]   line_nxt;
    logic [CW-1:0]           chunk_count;
    logic                    issue, zero_size, last_chunk, last_line;
    logic                    credit_avail, credit_zero;

    // one extra bit so rounding up a full-width hActive cannot wrap
    assign cpl_in = ({1'b0, hActive} + CHUNK_ROUND) >> CHUNK_BITS;

`ifdef VIDEO_SCHED_INTERLACE_EN
    assign start_line = {{(VACTIVE_BITS-1){1'b0}}, fieldOdd};
`else
    assign start_line = '0;
`endif

    assign zero_size  = (cpl_in == '0) || (start_line >= vActive);
    assign chunk_nxt  = {{(CHUNK_BITS+1){1'b0}}, chunk_count} + CHUNK_ONE;
    assign last_chunk = chunk_nxt == chunks_per_line;
    assign line_nxt   = {1'b0, line_count} + LINE_STEP;
    assign last_line  = line_nxt >= {1'b0, v_lim};

    // frameStart pre-empts everything: no write and no frameDone in that cycle
    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        frameDone = 1'b0;
        if (frameStart) begin
            state_n = zero_size ? DONE : ISSUE;
        end else begin
            case (state)
                IDLE: ;
                ISSUE: begin
                    issue = !requestFifoFull && credit_avail;
                    if (issue && last_chunk && last_line) state_n = DRAIN;
                end
                DRAIN: if (credit_zero) state_n = DONE;
                DONE: begin
                    frameDone = 1'b1;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge scalerClock) begin
        if (!resetN) begin
            state           <= IDLE;
            chunks_per_line <= '0;
            v_lim           <= '0;
            line_count      <= '0;
            chunk_count     <= '0;
        end else begin
            state <= state_n;
            if (frameStart) begin
                chunks_per_line <= cpl_in;
                v_lim           <= vActive;
                line_count      <= start_line;
                chunk_count     <= '0;
            end else if (issue) begin
                if (last_chunk) begin
                    chunk_count <= '0;
                    line_count  <= line_nxt[VACTIVE_BITS-1:0];
                end else begin
                    chunk_count <= chunk_nxt[CW-1:0];
                end
            end
        end
    end

    video_credit_counter #(.MAX(MAX_OUTSTANDING)) u_credit (
        .clk       (scalerClock),
        .reset_n   (resetN),
        .inc       (issue),
        .dec       (chunkConsumed),
        .available (credit_avail),
        .zero      (credit_zero),
        .underflow (creditUnderflow)
    );

    assign requestFifoWriteEnable = issue;
    assign requestFifoWriteData   = {line_count, chunk_count};
    assign busy                   = state != IDLE;
endmodule
